rvm_mem_ctrl: RTL
=================

# rvm_mem_ctrl

Memory controller sitting directly downstream of the core's memory port. It consumes the core's chip-enable / byte-enable request bus and drives a single-port synchronous SRAM, which has a registered read output and a configurable number of wait states. It generates the core's stall and error responses and checks every request for address range and alignment. Each transaction is a fixed-length sequence run by a small FSM with a wait-state counter.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of SRAM word 0; must be aligned to 4<<ADDR_W
- ADDR_W, 14, SRAM word-address width (capacity 4<<ADDR_W bytes)
- WAIT_CYCLES, 1, extra cycles after SRAM select before completion; legal range 1..15

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high reset
- core_addr  in  32  byte address from the core; must be word aligned
- core_wdata  in  32  write data from the core
- core_c_en  in  1  request valid; held high with all other request fields stable until completion
- core_b_en  in  4  write byte enables; 4'b0000 means read
- core_rdata  out  32  read data; valid only in the completion cycle
- core_error  out  1  high in the completion cycle of a rejected request
- core_stall  out  1  high while an accepted request is incomplete
- sram_cs  out  1  SRAM select, registered
- sram_we  out  4  SRAM byte write enables, registered
- sram_addr  out  ADDR_W  SRAM word address, registered
- sram_wdata  out  32  SRAM write data, registered
- sram_rdata  in  32  SRAM read data, valid the cycle after sram_cs

## Operation
- FSM states: IDLE, ACCESS, WAIT, DONE, ERR. On reset the FSM enters IDLE and the wait counter is cleared.
- A request is legal when both hold:
  - core_addr[1:0]==0;
  - (core_addr - BASE_ADDR) < (4<<ADDR_W), compared unsigned in 32 bits, so addresses below BASE wrap and are rejected.
- IDLE:
  - core_c_en=1 and the request is legal: latch the SRAM fields and go to ACCESS.
  - core_c_en=1 and the request is illegal: go to ERR. No SRAM access is made.
  - core_c_en=0: stay in IDLE.
- ACCESS, lasts one cycle:
  - sram_cs=1, sram_we=core_b_en, sram_addr=(core_addr-BASE_ADDR)>>2, sram_wdata=core_wdata.
  - Load the counter with WAIT_CYCLES-1 and go to WAIT.
- WAIT:
  - sram_cs=0, sram_we=0.
  - In the first WAIT cycle, capture sram_rdata into rdata_q. This happens for writes too, but the value is unused for a write.
  - While the counter is nonzero, decrement it.
  - When the counter is zero, go to DONE.
- DONE, lasts one cycle:
  - core_rdata=rdata_q for reads; 0 for writes.
  - Go to IDLE.
- ERR, lasts one cycle:
  - core_error=1, core_rdata=0.
  - Go to IDLE.
- core_stall = core_c_en && state∉{DONE, ERR}. This is combinational from core_c_en, so it is asserted in the same cycle as a new request.
- Back-to-back requests: a core_c_en seen in IDLE, in the cycle after DONE or ERR, is a new transaction.
- Protocol violation (core_c_en drops before completion): the FSM still runs the SRAM access to DONE, then returns to IDLE. The result is discarded and no error is raised.
- Reset asserted mid-transaction:
  - The FSM returns to IDLE immediately and all registered outputs clear.
  - The contents of an in-flight SRAM write are undefined.

## Timing
- Reset values: sram_cs=0, sram_we=0, sram_addr=0, sram_wdata=0, core_rdata=0, core_error=0, rdata_q=0.
- During reset, core_stall=core_c_en.
- Legal access: request seen in cycle 0, completion in cycle 2+WAIT_CYCLES. With the default WAIT_CYCLES=1 that is cycle 3.
- Cycle numbering for a legal access:
  - cycle 0: request seen in IDLE, core_stall=1;
  - cycle 1: ACCESS, sram_cs=1;
  - cycles 2..1+WAIT_CYCLES: WAIT;
  - cycle 2+WAIT_CYCLES: DONE.
- Illegal request: cycle 0 stall, cycle 1 ERR with core_stall=0 and core_error=1.
- Outside DONE and ERR, core_rdata and core_error are 0.
- sram_cs is high for exactly one cycle per legal transaction and never high in ERR.
- Throughput: one legal access every 3+WAIT_CYCLES cycles.

## Test plan
- Read, defaults: SRAM word 5 preloaded with 32'hDEADBEEF; request core_addr=32'h14, b_en=0 in cycle 0 -> sram_cs=1 with sram_addr=5 in cycle 1; core_stall=1 in cycles 0–2; in cycle 3, core_stall=0 and core_rdata=32'hDEADBEEF.
- Byte write: addr=32'h20, b_en=4'b0010, wdata=32'h0000AB00 -> sram_we=4'b0010 in cycle 1; a read-back of word 8 shows byte 1 = 8'hAB and all other bytes unchanged.
- Errors: misaligned addr=32'h22, and out-of-range addr=32'h0001_0000 (ADDR_W=14) -> for each, core_error=1 in cycle 1, sram_cs never asserted, core_rdata=0.
- Wrap below base: BASE_ADDR=32'h1000_0000, addr=32'h0FFF_FFFC -> error.
- WAIT_CYCLES=4: two back-to-back reads -> first completes in cycle 6, second request accepted in cycle 7 and completes in cycle 13.
- Reset in cycle 2 of a write: FSM returns to IDLE, all outputs at reset values, core_stall follows core_c_en; after release a new read completes normally.

Source files
------------

// File: rtl/rvm_mem_ctrl.sv
// rvm_mem_ctrl: bridges the core's c_en/b_en memory port to a single-port
// synchronous SRAM with registered read data and fixed wait states.
module rvm_mem_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned ADDR_W      = 14,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       core_addr,
    input  logic [31:0]       core_wdata,
    input  logic              core_c_en,
    input  logic [3:0]        core_b_en,
    output logic [31:0]       core_rdata,
    output logic              core_error,
    output logic              core_stall,
    output logic              sram_cs,
    output logic [3:0]        sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        WAIT,
        DONE,
        ERR
    } state_t;

    // 33 bits so that a 30-bit word address does not overflow the span.
    localparam logic [32:0] SPAN      = 33'd4 << ADDR_W;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [31:0]         rdata_q;
    logic                read_q;
    logic                cs_q;
    logic [3:0]          we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;

    logic [31:0]         offset;
    logic                legal;
    logic                accept;

    // Addresses below BASE wrap to large offsets and fail the range test.
    assign offset = core_addr - BASE_ADDR;
    assign legal  = (core_addr[1:0] == 2'b00) && ({1'b0, offset} < SPAN);
    assign accept = (state_q == IDLE) && core_c_en && legal;

    // Next-state and wait counter: fixed ACCESS -> WAIT* -> DONE sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (core_c_en) begin
                    state_d = legal ? ACCESS : ERR;
                end
            end
            ACCESS: begin
                cnt_d   = WAIT_INIT;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE, ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register and wait counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // SRAM request registers and read-data capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_q    <= 1'b0;
            we_q    <= 4'b0000;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            read_q  <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            cs_q <= accept;
            we_q <= accept ? core_b_en : 4'b0000;
            if (accept) begin
                addr_q  <= offset[ADDR_W+1:2];
                wdata_q <= core_wdata;
                read_q  <= (core_b_en == 4'b0000);
            end
            // First WAIT cycle is the one right after sram_cs.
            if (state_q == WAIT && cnt_q == WAIT_INIT) begin
                rdata_q <= sram_rdata;
            end
        end
    end

    assign sram_cs    = cs_q;
    assign sram_we    = we_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;

    assign core_rdata = (state_q == DONE && read_q) ? rdata_q : 32'd0;
    assign core_error = (state_q == ERR);
    assign core_stall = core_c_en && (state_q != DONE) && (state_q != ERR);

endmodule
